// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the program ROM address, latches
// the returned word into the IR, applies PC-relative branch redirects and halts on a zero word.
module fetch_unit #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_VECTOR  = 32'h0000_0800
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_InHigh,
    output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
    input  logic [DATAWIDTH_BUS-1:0] BusDatos,
    input  logic                     fetch_Stall_In,
    input  logic                     fetch_BranchTaken_In,
    output logic [DATAWIDTH_BUS-1:0] fetch_IR_Out,
    output logic [DATAWIDTH_BUS-1:0] fetch_IRPC_Out,
    output logic                     fetch_IRValid_Out,
    output logic                     fetch_Halted_Out
);

    typedef enum logic {RUN, HALT} state_t;

    state_t                   state_q, state_d;
    logic [DATAWIDTH_BUS-1:0] pc_q, pc_d;
    logic [DATAWIDTH_BUS-1:0] ir_q, ir_d;
    logic [DATAWIDTH_BUS-1:0] irpc_q, irpc_d;
    logic                     valid_q, valid_d;

    logic                     ir_is_branch;
    logic                     redirect;
    logic [DATAWIDTH_BUS-1:0] branch_target;

    assign ir_is_branch  = (ir_q[DATAWIDTH_BUS-1 -: 2] == 2'b00) && (ir_q[24:22] == 3'b010);
    assign redirect      = valid_q && fetch_BranchTaken_In && ir_is_branch;
    // Displacement is relative to the branch's own address, not the current PC.
    assign branch_target = irpc_q + {{(DATAWIDTH_BUS-22){ir_q[21]}}, ir_q[21:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        irpc_d  = irpc_q;
        valid_d = valid_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!fetch_Stall_In) begin
                    ir_d    = BusDatos;
                    irpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + DATAWIDTH_BUS'(1);
                    if (BusDatos == '0) state_d = HALT;
                end
            end
            HALT: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            irpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            irpc_q  <= irpc_d;
            valid_q <= valid_d;
        end
    end

    assign BusDirecciones    = pc_q;
    assign fetch_IR_Out      = ir_q;
    assign fetch_IRPC_Out    = irpc_q;
    assign fetch_IRValid_Out = valid_q;
    assign fetch_Halted_Out  = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan sequence plus randomized stimulus checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_InHigh = 1'b1;
    logic        fetch_Stall_In = 1'b0;
    logic        fetch_BranchTaken_In = 1'b0;
    logic [31:0] BusDirecciones, BusDatos, fetch_IR_Out, fetch_IRPC_Out;
    logic        fetch_IRValid_Out, fetch_Halted_Out;
    logic [31:0] bus2, dat2, ir2, irpc2;
    logic        valid2, halted2;

    int checks = 0;
    int errors = 0;
    bit directed = 1'b1;
    logic [31:0] rom_mem [64];

    // behavioural model state
    logic [31:0] m_pc, m_ir, m_irpc;
    logic        m_v, m_h;

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] rom_rd(input logic [31:0] a);
        if (!directed) return rom_mem[a[5:0]];
        case (a)
            32'h800: return 32'h8280_2001;
            32'h803: return 32'h8800_3FF6;
            32'h807: return 32'h0CBF_FFFC;
            32'h80D: return 32'h0080_0005;
            32'h80E: return 32'h0000_0000;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    always_comb BusDatos = rom_rd(BusDirecciones);
    always_comb dat2     = rom_rd(bus2);

    fetch_unit dut (
        .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh),
        .BusDirecciones(BusDirecciones), .BusDatos(BusDatos),
        .fetch_Stall_In(fetch_Stall_In), .fetch_BranchTaken_In(fetch_BranchTaken_In),
        .fetch_IR_Out(fetch_IR_Out), .fetch_IRPC_Out(fetch_IRPC_Out),
        .fetch_IRValid_Out(fetch_IRValid_Out), .fetch_Halted_Out(fetch_Halted_Out)
    );

    fetch_unit #(.DATAWIDTH_BUS(32), .RESET_VECTOR(32'hFFFF_FFFF)) dut_wrap (
        .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh),
        .BusDirecciones(bus2), .BusDatos(dat2),
        .fetch_Stall_In(fetch_Stall_In), .fetch_BranchTaken_In(fetch_BranchTaken_In),
        .fetch_IR_Out(ir2), .fetch_IRPC_Out(irpc2),
        .fetch_IRValid_Out(valid2), .fetch_Halted_Out(halted2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Spec rules applied to the model for one rising edge, using the inputs now on the pins.
    task automatic model_edge();
        logic [31:0] w;
        if (RESET_InHigh) begin
            m_pc = 32'h800; m_ir = 0; m_irpc = 0; m_v = 0; m_h = 0;
        end else if (!m_h) begin
            if (fetch_BranchTaken_In && m_v && m_ir[31:30] == 2'b00 && m_ir[24:22] == 3'b010) begin
                m_pc = m_irpc + 32'($signed(m_ir[21:0]));
                m_v  = 0;
            end else if (!fetch_Stall_In) begin
                w = rom_rd(m_pc);
                m_ir = w; m_irpc = m_pc; m_v = 1; m_pc = m_pc + 1;
                if (w == 0) m_h = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLOCK_50); #1;
        chk("pc",     BusDirecciones,    m_pc);
        chk("ir",     fetch_IR_Out,      m_ir);
        chk("irpc",   fetch_IRPC_Out,    m_irpc);
        chk("valid",  32'(fetch_IRValid_Out), 32'(m_v));
        chk("halted", 32'(fetch_Halted_Out),  32'(m_h));
        fetch_Stall_In = 1'b0;
        fetch_BranchTaken_In = 1'b0;
    endtask

    task automatic do_reset();
        RESET_InHigh = 1'b1;
        tick();
        tick();
        RESET_InHigh = 1'b0;
    endtask

    initial begin
        logic [31:0] frz_pc, frz_ir;
        int r;
        int halt_cnt;

        // reset: outputs zero, address at the reset vector
        do_reset();
        chk("rst_bus", BusDirecciones, 32'h800);
        chk("rst_ir", fetch_IR_Out, 32'h0);
        chk("rst_irpc", fetch_IRPC_Out, 32'h0);
        chk("rst_valid", 32'(fetch_IRValid_Out), 32'h0);
        chk("rst_halt", 32'(fetch_Halted_Out), 32'h0);
        chk("rst_bus_wrap", bus2, 32'hFFFF_FFFF);

        tick();
        chk("first_ir", fetch_IR_Out, 32'h8280_2001);
        chk("first_irpc", fetch_IRPC_Out, 32'h800);
        chk("first_valid", 32'(fetch_IRValid_Out), 32'h1);
        chk("wrap_irpc0", irpc2, 32'hFFFF_FFFF);
        chk("wrap_bus", bus2, 32'h0);
        tick();
        chk("wrap_irpc1", irpc2, 32'h0);
        chk("wrap_ir1", ir2, 32'hA000_0000);
        chk("wrap_valid", 32'(valid2), 32'h1);
        chk("wrap_halt", 32'(halted2), 32'h0);

        for (int i = 0; i < 4; i++) tick();
        chk("pre_stall_irpc", fetch_IRPC_Out, 32'h805);
        for (int i = 0; i < 3; i++) begin
            fetch_Stall_In = 1'b1;
            tick();
            chk("stall_irpc", fetch_IRPC_Out, 32'h805);
            chk("stall_bus", BusDirecciones, 32'h806);
        end
        tick();
        chk("post_stall_irpc", fetch_IRPC_Out, 32'h806);
        tick();
        chk("br_ir", fetch_IR_Out, 32'h0CBF_FFFC);

        // taken branch together with stall: redirect wins
        fetch_BranchTaken_In = 1'b1;
        fetch_Stall_In = 1'b1;
        tick();
        chk("bubble_valid", 32'(fetch_IRValid_Out), 32'h0);
        chk("bubble_bus", BusDirecciones, 32'h803);
        tick();
        chk("tgt_ir", fetch_IR_Out, 32'h8800_3FF6);
        chk("tgt_irpc", fetch_IRPC_Out, 32'h803);

        // taken pulse on a non-branch word is ignored
        fetch_BranchTaken_In = 1'b1;
        tick();
        chk("nonbr_irpc", fetch_IRPC_Out, 32'h804);

        // run past the untaken branch at 80D into the zero word at 80E
        for (int i = 0; i < 10; i++) tick();
        chk("halt_irpc", fetch_IRPC_Out, 32'h80E);
        chk("halt_ir", fetch_IR_Out, 32'h0);
        chk("halt_flag", 32'(fetch_Halted_Out), 32'h1);
        frz_pc = BusDirecciones;
        frz_ir = fetch_IRPC_Out;
        for (int i = 0; i < 10; i++) begin
            fetch_Stall_In = i[0];
            fetch_BranchTaken_In = ~i[0];
            tick();
            chk("frz_pc", BusDirecciones, frz_pc);
            chk("frz_irpc", fetch_IRPC_Out, frz_ir);
        end

        // reset asserted during a branch bubble
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("br2_ir", fetch_IR_Out, 32'h0CBF_FFFC);
        fetch_BranchTaken_In = 1'b1;
        tick();
        chk("br2_bubble", 32'(fetch_IRValid_Out), 32'h0);
        RESET_InHigh = 1'b1;
        tick();
        chk("midrst_bus", BusDirecciones, 32'h800);
        chk("midrst_valid", 32'(fetch_IRValid_Out), 32'h0);
        chk("midrst_irpc", fetch_IRPC_Out, 32'h0);

        // randomized phase with a small random ROM
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)
                rom_mem[i] = {2'b00, 5'($urandom), 3'b010, 22'($signed($urandom_range(0, 16)) - 8)};
            else if (r < 22)
                rom_mem[i] = 32'h0;
            else
                rom_mem[i] = 32'h8000_0000 | $urandom;
        end
        directed = 1'b0;
        tick();
        RESET_InHigh = 1'b0;
        halt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            halt_cnt = m_h ? halt_cnt + 1 : 0;
            RESET_InHigh = ($urandom_range(0, 99) < 2) || (halt_cnt > 6);
            fetch_Stall_In = ($urandom_range(0, 3) == 0);
            fetch_BranchTaken_In = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
